// File: rtl/cache_fill_ctrl.sv
// Shared I/D cache miss handler: fetches a 16-byte block from main memory for
// one cache at a time (dcache first) and passes write-through stores to memory.
module cache_fill_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        icache_miss_detected,
    input  logic [15:0] icache_miss_addr,
    input  logic        dcache_miss_detected,
    input  logic [15:0] dcache_miss_addr,
    input  logic        dcache_write_enable,
    input  logic [15:0] dcache_write_addr,
    input  logic [15:0] dcache_write_data,
    input  logic [15:0] mainmem_read_data,
    input  logic        mainmem_data_valid,
    output logic        stall_n,
    output logic [15:0] icache_fill_data,
    output logic [15:0] icache_fill_addr,
    output logic        icache_write_data_array,
    output logic        icache_write_tag_array,
    output logic [15:0] dcache_fill_data,
    output logic [15:0] dcache_fill_addr,
    output logic        dcache_write_data_array,
    output logic        dcache_write_tag_array,
    output logic [15:0] mainmem_addr,
    output logic [15:0] mainmem_write_data,
    output logic        mainmem_enable,
    output logic        mainmem_wr,
    output logic [1:0]  debug_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state, state_next;
    logic        owner, owner_next;          // 0 = icache, 1 = dcache
    logic [3:0]  issue_cnt, issue_cnt_next;
    logic [2:0]  rx_cnt, rx_cnt_next;
    logic [15:0] base, base_next;
    logic [15:0] rx_addr;

    assign debug_state = state;
    assign rx_addr     = base + {12'b0, rx_cnt, 1'b0};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= 1'b0;
            issue_cnt <= 4'd0;
            rx_cnt    <= 3'd0;
            base      <= 16'd0;
        end else begin
            state     <= state_next;
            owner     <= owner_next;
            issue_cnt <= issue_cnt_next;
            rx_cnt    <= rx_cnt_next;
            base      <= base_next;
        end
    end

    // Memory handshake: a request is accepted every cycle mainmem_enable=1 (no
    // back-pressure); read data returns in order, one word per cycle that
    // mainmem_data_valid=1, with no ready path back to memory.
    always_comb begin
        state_next              = state;
        owner_next              = owner;
        issue_cnt_next          = issue_cnt;
        rx_cnt_next             = rx_cnt;
        base_next               = base;
        icache_fill_data        = 16'd0;
        icache_fill_addr        = 16'd0;
        icache_write_data_array = 1'b0;
        icache_write_tag_array  = 1'b0;
        dcache_fill_data        = 16'd0;
        dcache_fill_addr        = 16'd0;
        dcache_write_data_array = 1'b0;
        dcache_write_tag_array  = 1'b0;
        mainmem_addr            = 16'd0;
        mainmem_write_data      = 16'd0;
        mainmem_enable          = 1'b0;
        mainmem_wr              = 1'b0;
        stall_n = (state == IDLE) & ~icache_miss_detected & ~dcache_miss_detected;

        case (state)
            IDLE: begin
                if (dcache_miss_detected) begin
                    owner_next     = 1'b1;
                    base_next      = dcache_miss_addr & 16'hFFF0;
                    issue_cnt_next = 4'd0;
                    rx_cnt_next    = 3'd0;
                    state_next     = FILL;
                end else if (icache_miss_detected) begin
                    owner_next     = 1'b0;
                    base_next      = icache_miss_addr & 16'hFFF0;
                    issue_cnt_next = 4'd0;
                    rx_cnt_next    = 3'd0;
                    state_next     = FILL;
                end else if (dcache_write_enable) begin
                    mainmem_enable     = 1'b1;
                    mainmem_wr         = 1'b1;
                    mainmem_addr       = dcache_write_addr;
                    mainmem_write_data = dcache_write_data;
                end
            end
            FILL: begin
                if (issue_cnt < 4'd8) begin
                    mainmem_enable = 1'b1;
                    mainmem_addr   = base + {11'b0, issue_cnt, 1'b0};
                    issue_cnt_next = issue_cnt + 4'd1;
                end
                if (mainmem_data_valid) begin
                    if (owner) begin
                        dcache_fill_data        = mainmem_read_data;
                        dcache_fill_addr        = rx_addr;
                        dcache_write_data_array = 1'b1;
                        dcache_write_tag_array  = (rx_cnt == 3'd7);
                    end else begin
                        icache_fill_data        = mainmem_read_data;
                        icache_fill_addr        = rx_addr;
                        icache_write_data_array = 1'b1;
                        icache_write_tag_array  = (rx_cnt == 3'd7);
                    end
                    rx_cnt_next = rx_cnt + 3'd1;
                    if (rx_cnt == 3'd7)
                        state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // A reset cycle must not leak requests or strobes from an aborted fill.
        if (rst) begin
            icache_fill_data        = 16'd0;
            icache_fill_addr        = 16'd0;
            icache_write_data_array = 1'b0;
            icache_write_tag_array  = 1'b0;
            dcache_fill_data        = 16'd0;
            dcache_fill_addr        = 16'd0;
            dcache_write_data_array = 1'b0;
            dcache_write_tag_array  = 1'b0;
            mainmem_addr            = 16'd0;
            mainmem_write_data      = 16'd0;
            mainmem_enable          = 1'b0;
            mainmem_wr              = 1'b0;
        end
    end

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Bench for cache_fill_ctrl: IDLE vector table, directed fill/store/reset
// sequences and random transactions against a block-level memory/cache model.
module tb_cache_fill_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        icache_miss_detected, dcache_miss_detected, dcache_write_enable;
    logic [15:0] icache_miss_addr, dcache_miss_addr, dcache_write_addr, dcache_write_data;
    logic [15:0] mainmem_read_data;
    logic        mainmem_data_valid;
    logic        stall_n;
    logic [15:0] icache_fill_data, icache_fill_addr, dcache_fill_data, dcache_fill_addr;
    logic        icache_write_data_array, icache_write_tag_array;
    logic        dcache_write_data_array, dcache_write_tag_array;
    logic [15:0] mainmem_addr, mainmem_write_data;
    logic        mainmem_enable, mainmem_wr;
    logic [1:0]  debug_state;

    localparam logic [1:0] ST_IDLE = 2'd0;

    always #5 clk = ~clk;

    cache_fill_ctrl dut (
        .clk(clk), .rst(rst),
        .icache_miss_detected(icache_miss_detected), .icache_miss_addr(icache_miss_addr),
        .dcache_miss_detected(dcache_miss_detected), .dcache_miss_addr(dcache_miss_addr),
        .dcache_write_enable(dcache_write_enable), .dcache_write_addr(dcache_write_addr),
        .dcache_write_data(dcache_write_data),
        .mainmem_read_data(mainmem_read_data), .mainmem_data_valid(mainmem_data_valid),
        .stall_n(stall_n),
        .icache_fill_data(icache_fill_data), .icache_fill_addr(icache_fill_addr),
        .icache_write_data_array(icache_write_data_array),
        .icache_write_tag_array(icache_write_tag_array),
        .dcache_fill_data(dcache_fill_data), .dcache_fill_addr(dcache_fill_addr),
        .dcache_write_data_array(dcache_write_data_array),
        .dcache_write_tag_array(dcache_write_tag_array),
        .mainmem_addr(mainmem_addr), .mainmem_write_data(mainmem_write_data),
        .mainmem_enable(mainmem_enable), .mainmem_wr(mainmem_wr),
        .debug_state(debug_state)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc_g    = 0;
    always @(posedge clk) cyc_g <= cyc_g + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc_g);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] val);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got event with value %0h, required none (cycle %0d)", name, val, cyc_g);
    endtask

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    // ---------------- memory model: fixed latency, in-order ----------------
    logic [15:0] pend_addr[$];
    int          pend_due[$];
    int          mem_lat = 4;

    task automatic mem_drive();
        if (pend_due.size() > 0 && pend_due[0] == cyc_g) begin
            mainmem_data_valid = 1'b1;
            mainmem_read_data  = mem_word(pend_addr[0]);
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end else begin
            mainmem_data_valid = 1'b0;
            mainmem_read_data  = 16'($urandom);
        end
    endtask

    task automatic mem_sample();
        if (mainmem_enable && !mainmem_wr) begin
            pend_addr.push_back(mainmem_addr);
            pend_due.push_back(cyc_g + mem_lat);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [15:0] exp_rd_q[$];
    logic [32:0] exp_fill_q[$];   // {owner, addr, data}
    logic [16:0] exp_tag_q[$];    // {owner, addr}
    logic [31:0] exp_wr_q[$];     // {addr, data}
    logic drop_im, drop_dm, drop_we, tag_prev;
    int   rd_idx, last_rd_cyc;

    task automatic add_fill(input logic owner, input logic [15:0] base);
        for (int k = 0; k < 8; k++) begin
            logic [15:0] a;
            a = base + 16'(2 * k);
            exp_rd_q.push_back(a);
            exp_fill_q.push_back({owner, a, mem_word(a)});
        end
        exp_tag_q.push_back({owner, base + 16'd14});
    endtask

    task automatic observe();
        logic in_done, istb, dstb;
        logic [32:0] ef;
        logic [16:0] et;
        in_done = tag_prev;
        tag_prev = 1'b0;
        istb = icache_write_data_array;
        dstb = dcache_write_data_array;
        mem_sample();

        check("stall_n", 32'(stall_n),
              32'(!icache_miss_detected && !dcache_miss_detected && !in_done));

        if (mainmem_enable && !mainmem_wr) begin
            if (exp_rd_q.size() == 0) unexpected("read_issue", 32'(mainmem_addr));
            else begin
                check("read_addr", 32'(mainmem_addr), 32'(exp_rd_q.pop_front()));
                if (rd_idx % 8 != 0) check("read_consecutive", 32'(cyc_g - last_rd_cyc), 32'd1);
                rd_idx++;
                last_rd_cyc = cyc_g;
            end
        end

        if (istb && dstb) unexpected("both_strobes", 32'd3);
        if (istb || dstb) begin
            if (exp_fill_q.size() == 0) unexpected("fill_strobe", 32'(dstb));
            else begin
                ef = exp_fill_q.pop_front();
                check("fill_owner", 32'(dstb), 32'(ef[32]));
                check("fill_addr", 32'(dstb ? dcache_fill_addr : icache_fill_addr), 32'(ef[31:16]));
                check("fill_data", 32'(dstb ? dcache_fill_data : icache_fill_data), 32'(ef[15:0]));
            end
            check("nonowner_zero", dstb ? {icache_fill_addr, icache_fill_data}
                                        : {dcache_fill_addr, dcache_fill_data}, 32'd0);
        end

        if (icache_write_tag_array || dcache_write_tag_array) begin
            check("tag_with_data", 32'({icache_write_tag_array, dcache_write_tag_array}),
                  32'({istb, dstb}));
            if (exp_tag_q.size() == 0) unexpected("tag_strobe", 32'(dcache_write_tag_array));
            else begin
                et = exp_tag_q.pop_front();
                check("tag", 32'({dcache_write_tag_array,
                                  dcache_write_tag_array ? dcache_fill_addr : icache_fill_addr}),
                      32'(et));
            end
            if (dcache_write_tag_array) drop_dm = 1'b1;
            if (icache_write_tag_array) drop_im = 1'b1;
            tag_prev = 1'b1;
        end

        if (mainmem_wr) begin
            check("wr_enable", 32'(mainmem_enable), 32'd1);
            if (exp_wr_q.size() == 0 || exp_fill_q.size() != 0 ||
                icache_miss_detected || dcache_miss_detected)
                unexpected("early_or_extra_write", 32'(mainmem_addr));
            else begin
                check("write", {mainmem_addr, mainmem_write_data}, exp_wr_q.pop_front());
                drop_we = 1'b1;
            end
        end
    endtask

    task automatic apply_drops();
        if (drop_im) icache_miss_detected = 1'b0;
        if (drop_dm) dcache_miss_detected = 1'b0;
        if (drop_we) dcache_write_enable  = 1'b0;
        drop_im = 1'b0; drop_dm = 1'b0; drop_we = 1'b0;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        icache_miss_detected = 1'b0; dcache_miss_detected = 1'b0;
        dcache_write_enable = 1'b0; mainmem_data_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        pend_addr.delete(); pend_due.delete();
    endtask

    task automatic run_txn(input logic im, input logic [15:0] ia, input logic dm,
                           input logic [15:0] da, input logic we, input logic [15:0] wa,
                           input logic [15:0] wd, input int lat);
        bit finished;
        mem_lat = lat;
        rd_idx = 0; last_rd_cyc = 0;
        drop_im = 1'b0; drop_dm = 1'b0; drop_we = 1'b0; tag_prev = 1'b0;
        if (dm) add_fill(1'b1, da & 16'hFFF0);
        if (im) add_fill(1'b0, ia & 16'hFFF0);
        if (we) exp_wr_q.push_back({wa, wd});
        @(posedge clk); #1;
        icache_miss_detected = im; icache_miss_addr = ia;
        dcache_miss_detected = dm; dcache_miss_addr = da;
        dcache_write_enable = we; dcache_write_addr = wa; dcache_write_data = wd;
        mem_drive();
        finished = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            observe();
            if (exp_rd_q.size() == 0 && exp_fill_q.size() == 0 && exp_tag_q.size() == 0 &&
                exp_wr_q.size() == 0 && pend_due.size() == 0 && !tag_prev &&
                !icache_miss_detected && !dcache_miss_detected && !dcache_write_enable) begin
                finished = 1'b1;
                break;
            end
            @(posedge clk); #1;
            apply_drops();
            mem_drive();
        end
        if (!finished) begin
            unexpected("txn_timeout", 32'(exp_fill_q.size()));
            exp_rd_q.delete(); exp_fill_q.delete(); exp_tag_q.delete(); exp_wr_q.delete();
            pulse_reset();
        end
    endtask

    // Abort a dcache fill with reset once three words have landed.
    task automatic reset_mid_fill();
        int strobes;
        mem_lat = 4;
        strobes = 0;
        @(posedge clk); #1;
        dcache_miss_detected = 1'b1; dcache_miss_addr = 16'h1236;
        mem_drive();
        for (int c = 0; c < 40 && strobes < 3; c++) begin
            @(negedge clk);
            mem_sample();
            if (dcache_write_data_array) strobes++;
            if (dcache_write_tag_array) unexpected("early_tag", 32'(dcache_fill_addr));
            if (strobes < 3) begin
                @(posedge clk); #1;
                mem_drive();
            end
        end
        check("three_words_seen", 32'(strobes), 32'd3);
        @(posedge clk); #1;
        rst = 1'b1; dcache_miss_detected = 1'b0;
        mem_drive();
        @(negedge clk);
        mem_sample();
        check("rst_cycle_outputs", 32'({mainmem_enable, mainmem_wr, dcache_write_data_array,
                                        dcache_write_tag_array, icache_write_data_array,
                                        icache_write_tag_array}), 32'd0);
        check("rst_cycle_fill", {dcache_fill_addr, dcache_fill_data}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        mem_drive();
        @(negedge clk);
        check("after_rst_state", 32'(debug_state), 32'(ST_IDLE));
        check("after_rst_stall_n", 32'(stall_n), 32'd1);
        for (int c = 0; c < 6; c++) begin
            check("late_valid_quiet", 32'({mainmem_enable, dcache_write_data_array,
                                           dcache_write_tag_array, icache_write_data_array,
                                           icache_write_tag_array}), 32'd0);
            @(posedge clk); #1;
            mem_drive();
            @(negedge clk);
        end
        pend_addr.delete(); pend_due.delete();
        mainmem_data_valid = 1'b0;
    endtask

    typedef struct {
        logic        im;
        logic        dm;
        logic        we;
        logic [15:0] wa;
        logic [15:0] wd;
        logic        stall;
        logic        en;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdat;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 16'h3002, 16'hBEEF, 1'b1, 1'b1, 1'b1, 16'h3002, 16'hBEEF};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 16'h0000, 16'hFFFF, 1'b1, 1'b1, 1'b1, 16'h0000, 16'hFFFF};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 16'h4004, 16'h1111, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000};
        vecs[6] = '{1'b1, 1'b1, 1'b1, 16'h5006, 16'h2222, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000};
        vecs[7] = '{1'b1, 1'b0, 1'b1, 16'hFFFE, 16'h1234, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000};

        rst = 1'b1;
        icache_miss_detected = 1'b0; icache_miss_addr = 16'h0046;
        dcache_miss_detected = 1'b0; dcache_miss_addr = 16'h2008;
        dcache_write_enable = 1'b0; dcache_write_addr = 16'h0; dcache_write_data = 16'h0;
        mainmem_read_data = 16'h0; mainmem_data_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", 32'({mainmem_enable, mainmem_wr, icache_write_data_array,
                                    icache_write_tag_array, dcache_write_data_array,
                                    dcache_write_tag_array}), 32'd0);
        check("reset_fill_zero", {icache_fill_addr, dcache_fill_addr}, 32'd0);
        check("reset_stall_n", 32'(stall_n), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_state", 32'(debug_state), 32'(ST_IDLE));

        // IDLE decode table
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            icache_miss_detected = vecs[i].im; dcache_miss_detected = vecs[i].dm;
            dcache_write_enable = vecs[i].we;
            dcache_write_addr = vecs[i].wa; dcache_write_data = vecs[i].wd;
            @(negedge clk);
            check($sformatf("vec%0d_stall_n", i), 32'(stall_n), 32'(vecs[i].stall));
            check($sformatf("vec%0d_en_wr", i), 32'({mainmem_enable, mainmem_wr}),
                  32'({vecs[i].en, vecs[i].wr}));
            if (vecs[i].en)
                check($sformatf("vec%0d_addr_data", i), {mainmem_addr, mainmem_write_data},
                      {vecs[i].addr, vecs[i].wdat});
            pulse_reset();
        end

        // Directed block-level sequences
        run_txn(1'b1, 16'h0046, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 4);
        run_txn(1'b1, 16'h0100, 1'b1, 16'h2008, 1'b0, 16'h0000, 16'h0000, 4);
        run_txn(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h3002, 16'hBEEF, 4);
        run_txn(1'b0, 16'h0000, 1'b1, 16'h4004, 1'b1, 16'h4004, 16'hCAFE, 4);
        run_txn(1'b0, 16'h0000, 1'b1, 16'hFFFA, 1'b0, 16'h0000, 16'h0000, 4);
        run_txn(1'b1, 16'hFFFE, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1);
        reset_mid_fill();

        // Random transactions
        for (int t = 0; t < 30; t++) begin
            int kind;
            logic im, dm, we;
            kind = $urandom_range(0, 5);
            im = (kind == 0 || kind == 2 || kind == 5);
            dm = (kind == 1 || kind == 2 || kind == 4);
            we = (kind == 3 || kind == 4 || kind == 5);
            run_txn(im, 16'($urandom) & 16'hFFFE, dm, 16'($urandom) & 16'hFFFE,
                    we, 16'($urandom) & 16'hFFFE, 16'($urandom), $urandom_range(1, 6));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required end of test");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cache_fill_ctrl.md
CACHE_FILL_CTRL -- requirements
Module: cache_fill_ctrl

Interface
REQ-001 Parameters: none; block size fixed at 16 bytes (8 x 16-bit words), addresses byte-granular, word-aligned.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 icache_miss_detected  in  1  instruction cache lookup missed this cycle.
REQ-005 icache_miss_addr  in  16  byte address of missing instruction.
REQ-006 dcache_miss_detected  in  1  data cache lookup missed this cycle.
REQ-007 dcache_miss_addr  in  16  byte address of missing data.
REQ-008 dcache_write_enable  in  1  MEM-stage store, write-through request.
REQ-009 dcache_write_addr  in  16  store byte address.
REQ-010 dcache_write_data  in  16  store data.
REQ-011 mainmem_read_data  in  16  memory read data.
REQ-012 mainmem_data_valid  in  1  mainmem_read_data valid this cycle.
REQ-013 stall_n  out  1  0 = freeze whole pipeline.
REQ-014 icache_fill_data / dcache_fill_data  out  16 each  word to write into data array.
REQ-015 icache_fill_addr / dcache_fill_addr  out  16 each  byte address of fill word.
REQ-016 icache_write_data_array / dcache_write_data_array  out  1 each  data-array write strobe.
REQ-017 icache_write_tag_array / dcache_write_tag_array  out  1 each  tag/valid write strobe.
REQ-018 mainmem_addr  out  16; mainmem_write_data  out  16; mainmem_enable  out  1; mainmem_wr  out  1.

Function
REQ-019 States: IDLE, FILL, DONE; 1-bit owner register (0 = icache, 1 = dcache); 4-bit issue_cnt (0..8); 3-bit rx_cnt (0..7); 16-bit base register.
REQ-020 IDLE, either miss asserted: latch base = miss_addr & 16'hFFF0, owner, zero both counters, go FILL next cycle.
REQ-021 Simultaneous icache and dcache miss: dcache served first; icache miss served after return to IDLE (it stays asserted since pipeline is stalled).
REQ-022 IDLE, no miss, dcache_write_enable=1: same cycle drive mainmem_enable=1, mainmem_wr=1, mainmem_addr=dcache_write_addr, mainmem_write_data=dcache_write_data; stay IDLE; no stall.
REQ-023 Store that also misses: fill first, no memory write while FILL/DONE; write issued per REQ-022 on first IDLE cycle with miss cleared.
REQ-024 FILL issue: while issue_cnt<8 drive mainmem_enable=1, mainmem_wr=0, mainmem_addr = base + 2*issue_cnt; increment issue_cnt each cycle; one read per cycle, 8 consecutive cycles.
REQ-025 FILL receive: each cycle with mainmem_data_valid=1, owner fill_data = mainmem_read_data, owner fill_addr = base + 2*rx_cnt, owner write_data_array=1; rx_cnt increments (wraps 7->0 only on last word).
REQ-026 Last word (rx_cnt=7 and data_valid=1): owner write_tag_array=1 same cycle; next state DONE.
REQ-027 DONE lasts exactly one cycle (cache re-lookup), then IDLE.
REQ-028 mainmem_data_valid outside FILL is ignored; no strobes.
REQ-029 Non-owner strobes always 0; fill_data/fill_addr of non-owner are don't-care but driven 0.
REQ-030 stall_n = (state==IDLE) & ~icache_miss_detected & ~dcache_miss_detected, combinational.
REQ-031 mainmem_enable=0 and mainmem_wr=0 in all cases not covered by REQ-022/REQ-024.
REQ-032 All address arithmetic 16-bit modulo 2^16; base 16'hFFF0 fills FFF0..FFFE with no wrap.

Reset
REQ-033 rst=1 at a clock edge: state IDLE, owner 0, counters 0, base 0; takes priority over all transitions.
REQ-034 During/after reset: all strobes, mainmem_enable, mainmem_wr 0; fill data/addr 0; stall_n follows REQ-030.
REQ-035 Reset mid-fill aborts it; no tag write; in-flight data_valid after reset ignored.

Verification
REQ-036 icache miss addr 16'h0046, memory 4-cycle latency -> reads 0040..004E on 8 consecutive cycles, 8 icache_write_data_array pulses addrs 0040..004E, tag pulse with word at 004E, DONE, stall_n high once miss drops.
REQ-037 icache miss 0x0100 and dcache miss 0x2008 same cycle -> dcache fills 2000..200E first, then icache 0100..010E; no icache strobe during dcache fill.
REQ-038 IDLE store addr 0x3002 data 0xBEEF, no miss -> same cycle enable=1, wr=1, addr 3002, data BEEF; stall_n=1.
REQ-039 Store to 0x4004 that misses -> fill 4000..400E, zero writes until IDLE, then single write to 4004.
REQ-040 rst asserted after 3rd returned word of a fill -> next cycle IDLE, no tag strobe, late data_valid produces no strobes.
REQ-041 dcache miss at 0xFFFA -> fill addrs FFF0..FFFE, no wrap to 0000.
